// File: rtl/pio_read_scheduler_if.sv
// Bundle between the software master, the PIO input slave and the read scheduler.
// The scheduler uses the slave modport; the environment side uses master.
interface pio_read_scheduler_if #(
  parameter int DATA_W = 12
);
  logic              sw_read;
  logic [1:0]        sw_address;
  logic              sw_waitrequest;
  logic [31:0]       sw_readdata;
  logic [1:0]        pio_address;
  logic [31:0]       pio_readdata;
  logic              poll_enable;
  logic [DATA_W-1:0] poll_value;
  logic              poll_changed;
  logic              poll_overrun;

  modport slave (
    input  sw_read, sw_address, pio_readdata, poll_enable,
    output sw_waitrequest, sw_readdata, pio_address,
           poll_value, poll_changed, poll_overrun
  );

  modport master (
    output sw_read, sw_address, pio_readdata, poll_enable,
    input  sw_waitrequest, sw_readdata, pio_address,
           poll_value, poll_changed, poll_overrun
  );
endinterface

// File: rtl/pio_read_scheduler.sv
// Arbitrates a single PIO input slave between software reads and a periodic
// poll of address 0, round-robin when both want it at once.
module pio_read_scheduler #(
  parameter int POLL_PERIOD = 1024,
  parameter int DATA_W      = 12
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pio_read_scheduler_if.slave    bus
);

  localparam logic [15:0] POLL_RELOAD = 16'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    SW_ADDR,
    SW_CAP,
    SW_DONE,
    POLL_ADDR,
    POLL_CAP
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       poll_cnt_q, poll_cnt_d;
  logic              poll_pending_q, poll_pending_d;
  logic              poll_overrun_q, poll_overrun_d;
  logic              last_grant_poll_q, last_grant_poll_d;
  logic [1:0]        pio_address_q, pio_address_d;
  logic              sw_waitrequest_q, sw_waitrequest_d;
  logic [31:0]       sw_readdata_q, sw_readdata_d;
  logic [DATA_W-1:0] poll_value_q, poll_value_d;
  logic              poll_changed_q, poll_changed_d;
  logic              poll_tick;

  // Poll timer, pending request and overrun flag
  always_comb begin
    poll_tick      = bus.poll_enable && (poll_cnt_q == 16'd0);
    poll_cnt_d     = poll_cnt_q;
    poll_pending_d = poll_pending_q;
    poll_overrun_d = poll_overrun_q;

    if (!bus.poll_enable || poll_tick) begin
      poll_cnt_d = POLL_RELOAD;
    end else begin
      poll_cnt_d = poll_cnt_q - 16'd1;
    end

    if (state_q == POLL_CAP) begin
      poll_pending_d = 1'b0;
    end
    // A tick landing on the servicing cycle re-arms the request instead of overrunning.
    if (poll_tick) begin
      if (poll_pending_q && (state_q != POLL_CAP)) begin
        poll_overrun_d = 1'b1;
      end
      poll_pending_d = 1'b1;
    end
  end

  // Arbitration and transaction sequencing
  always_comb begin
    state_d           = state_q;
    last_grant_poll_d = last_grant_poll_q;
    sw_readdata_d     = sw_readdata_q;
    poll_value_d      = poll_value_q;
    poll_changed_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.sw_read && (!poll_pending_q || last_grant_poll_q)) begin
          state_d           = SW_ADDR;
          last_grant_poll_d = 1'b0;
        end else if (poll_pending_q) begin
          state_d           = POLL_ADDR;
          last_grant_poll_d = 1'b1;
        end
      end
      SW_ADDR: state_d = SW_CAP;
      SW_CAP: begin
        sw_readdata_d = bus.pio_readdata;
        state_d       = SW_DONE;
      end
      SW_DONE:   state_d = IDLE;
      POLL_ADDR: state_d = POLL_CAP;
      POLL_CAP: begin
        poll_value_d   = bus.pio_readdata[DATA_W-1:0];
        poll_changed_d = (bus.pio_readdata[DATA_W-1:0] != poll_value_q);
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Address is captured at grant and held through the capture cycle.
    if (state_d == SW_ADDR) begin
      pio_address_d = bus.sw_address;
    end else if (state_d == SW_CAP) begin
      pio_address_d = pio_address_q;
    end else begin
      pio_address_d = 2'd0;
    end

    sw_waitrequest_d = (state_d != SW_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= IDLE;
      poll_cnt_q        <= POLL_RELOAD;
      poll_pending_q    <= 1'b0;
      poll_overrun_q    <= 1'b0;
      last_grant_poll_q <= 1'b1;
      pio_address_q     <= 2'd0;
      sw_waitrequest_q  <= 1'b1;
      sw_readdata_q     <= 32'd0;
      poll_value_q      <= '0;
      poll_changed_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      poll_cnt_q        <= poll_cnt_d;
      poll_pending_q    <= poll_pending_d;
      poll_overrun_q    <= poll_overrun_d;
      last_grant_poll_q <= last_grant_poll_d;
      pio_address_q     <= pio_address_d;
      sw_waitrequest_q  <= sw_waitrequest_d;
      sw_readdata_q     <= sw_readdata_d;
      poll_value_q      <= poll_value_d;
      poll_changed_q    <= poll_changed_d;
    end
  end

  assign bus.sw_waitrequest = sw_waitrequest_q;
  assign bus.sw_readdata    = sw_readdata_q;
  assign bus.pio_address    = pio_address_q;
  assign bus.poll_value     = poll_value_q;
  assign bus.poll_changed   = poll_changed_q;
  assign bus.poll_overrun   = poll_overrun_q;

endmodule
